// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
//   Shared widths and constants for the audio sample path, plus the
//   12-bit saturation helper used by the volume datapath.
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_IN_W  = 12;
    localparam int SAMPLE_OUT_W = 16;
    localparam int GAIN_W       = 4;

    localparam logic [GAIN_W-1:0]      GAIN_UNITY = 4'd8;
    localparam logic [GAIN_W-1:0]      GAIN_MAX   = 4'd15;
    localparam logic [GAIN_W-1:0]      GAIN_MIN   = 4'd0;
    localparam logic [SAMPLE_IN_W-1:0] MID_CODE   = 12'h800;

    // Saturated 12-bit sample with its clip flag.
    typedef struct packed {
        logic [SAMPLE_IN_W-1:0] val;
        logic                   clip;
    } sat12_t;

    // Clamp a signed 17-bit scaled value into the signed 12-bit range.
    function automatic sat12_t sat12(input logic signed [16:0] q);
        sat12_t r;
        if (q > 17'sd2047) begin
            r.val  = 12'h7FF;
            r.clip = 1'b1;
        end else if (q < -17'sd2048) begin
            r.val  = 12'h800;
            r.clip = 1'b1;
        end else begin
            r.val  = q[11:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Two-flop synchroniser, hold-time debouncer and rising-edge detector for
//   one raw push button. Emits a single-cycle pulse per accepted press;
//   holding the button produces no repeat.
// Ports
//   clk    in  1  clock
//   rst    in  1  asynchronous active-high reset
//   btn    in  1  raw asynchronous button level
//   pulse  out 1  one-cycle strobe on each debounced rising edge
// ----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchroniser shift, hold counter and edge detect.
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // The counter only runs while the synchronised level disagrees with
        // the accepted level; any bounce back restarts the hold window.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
        pulse_d = stable_d & ~stable_q;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/volume_stage.sv
// ----------------------------------------------------------------------------
// volume_stage
//   Button-controlled digital volume between the effect mux and the I2S
//   transmitter. Offset-binary 12-bit in, signed {sat12,4'b0} 16-bit out,
//   gain in Q1.3 (0..1.875), two-cycle latency at full throughput.
// Ports
//   clk           in  1   sample clock
//   rst           in  1   asynchronous active-high reset
//   plus, minus   in  1   raw volume buttons
//   sample_in     in  12  offset-binary sample (0x800 = silence)
//   sample_valid  in  1   sample_in strobe
//   sample_out    out 16  scaled, saturated signed sample
//   out_valid     out 1   sample_out strobe
//   clip          out 1   sample saturated (with out_valid)
//   gain          out 4   target gain
// Configuration
//   VOLUME_ZC_EN  when defined, gain changes take effect on a zero crossing
//                 of the input (or after ZC_TIMEOUT valid samples).
// ----------------------------------------------------------------------------
module volume_stage
    import audio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int GAIN_RESET      = 8,
    parameter int ZC_TIMEOUT      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        plus,
    input  logic        minus,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] sample_out,
    output logic        out_valid,
    output logic        clip,
    output logic [3:0]  gain
);

    localparam logic [GAIN_W-1:0] GAIN_RST_C = GAIN_W'(GAIN_RESET);

    logic              plus_step, minus_step;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W-1:0] gain_active;
    logic [12:0]       c_q, c_d;
    logic              v1_q, v1_d;
    logic [15:0]       sample_out_q, sample_out_d;
    logic              out_valid_q, out_valid_d;
    logic              clip_q, clip_d;
    logic signed [16:0] p_s;
    logic signed [16:0] q_s;
    sat12_t            sat_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_plus (
        .clk   (clk),
        .rst   (rst),
        .btn   (plus),
        .pulse (plus_step)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_minus (
        .clk   (clk),
        .rst   (rst),
        .btn   (minus),
        .pulse (minus_step)
    );

    // Target gain: saturating step up/down; simultaneous steps cancel.
    always_comb begin
        gain_d = gain_q;
        if (plus_step && !minus_step) begin
            if (gain_q == GAIN_MAX) begin
                gain_d = gain_q;
            end else begin
                gain_d = gain_q + 4'd1;
            end
        end else if (minus_step && !plus_step) begin
            if (gain_q == GAIN_MIN) begin
                gain_d = gain_q;
            end else begin
                gain_d = gain_q - 4'd1;
            end
        end else begin
            gain_d = gain_q;
        end
    end

`ifdef VOLUME_ZC_EN
    localparam int                TO_W     = $clog2(ZC_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ZC_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);

    logic [GAIN_W-1:0] gain_act_q, gain_act_d;
    logic              prev_neg_q, prev_neg_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              zc_s;

    // Apply a pending gain on the S1 sample that crosses zero, or on timeout.
    always_comb begin
        gain_act_d = gain_act_q;
        prev_neg_d = prev_neg_q;
        to_cnt_d   = to_cnt_q;
        zc_s       = (c_d == 13'd0) || (c_d[12] != prev_neg_q);
        if (sample_valid) begin
            prev_neg_d = c_d[12];
            if (gain_q != gain_act_q) begin
                if (zc_s || (to_cnt_q == TO_LAST)) begin
                    gain_act_d = gain_q;
                    to_cnt_d   = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end else begin
                to_cnt_d = '0;
            end
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Zero-crossing tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_act_q <= GAIN_RST_C;
            prev_neg_q <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            gain_act_q <= gain_act_d;
            prev_neg_q <= prev_neg_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign gain_active = gain_act_q;
`else
    assign gain_active = gain_q;
`endif

    // Two-stage datapath: S1 recentres, S2 scales and saturates.
    always_comb begin
        c_d  = {1'b0, sample_in} - {1'b0, MID_CODE};
        v1_d = sample_valid;
        p_s  = $signed({{4{c_q[12]}}, c_q}) * $signed({13'd0, gain_active});
        // Arithmetic shift rounds toward -inf, matching the Q1.3 gain.
        q_s  = p_s >>> 3;
        sat_s = sat12(q_s);
        out_valid_d = v1_q;
        if (v1_q) begin
            sample_out_d = {sat_s.val, 4'b0000};
            clip_d       = sat_s.clip;
        end else begin
            sample_out_d = sample_out_q;
            clip_d       = 1'b0;
        end
    end

    // Gain and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_q       <= GAIN_RST_C;
            c_q          <= 13'd0;
            v1_q         <= 1'b0;
            sample_out_q <= 16'h0000;
            out_valid_q  <= 1'b0;
            clip_q       <= 1'b0;
        end else begin
            gain_q       <= gain_d;
            c_q          <= c_d;
            v1_q         <= v1_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            clip_q       <= clip_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign clip       = clip_q;
    assign gain       = gain_q;

endmodule
